// File: rtl/rs_bypass_unit.sv
// Operand bypass unit: tracks in-flight destination tags, forwards the
// youngest matching stage result to rs1/rs2 and flags load-use hazards.
module rs_bypass_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_READY = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    io_issue_valid,
    input  logic [4:0]              io_issue_rd,
    input  logic                    io_issue_wen,
    input  logic                    io_issue_is_load,
    input  logic                    io_advance,
    input  logic                    io_flush,
    input  logic [4:0]              io_rs1_addr,
    input  logic [4:0]              io_rs2_addr,
    input  logic [XLEN-1:0]         io_rs1,
    input  logic [XLEN-1:0]         io_rs2,
    input  logic [DEPTH*XLEN-1:0]   io_stage_data,
    output logic [XLEN-1:0]         io_rs1_out,
    output logic [XLEN-1:0]         io_rs2_out,
    output logic [2:0]              io_rs1_sel,
    output logic [2:0]              io_rs2_sel,
    output logic                    io_stall,
    output logic [31:0]             io_stall_count
);

    localparam int unsigned SEL_W = 3;
    localparam int unsigned CNT_W = 32;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } tag_t;

    tag_t               entries_q [DEPTH];
    logic [CNT_W-1:0]   stall_count_q;

    logic               hit1, rdy1, hit2, rdy2;
    logic [SEL_W-1:0]   sel1, sel2;
    logic [XLEN-1:0]    data1, data2;
    logic               stall_c;
    logic               capture_c;

    // Youngest-match search per source; scanning old-to-young lets the
    // lowest index overwrite any older hit.
    always_comb begin
        hit1  = 1'b0;
        rdy1  = 1'b0;
        sel1  = '0;
        data1 = '0;
        hit2  = 1'b0;
        rdy2  = 1'b0;
        sel2  = '0;
        data2 = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (entries_q[i].valid && (entries_q[i].rd == io_rs1_addr) &&
                (io_rs1_addr != 5'd0)) begin
                hit1  = 1'b1;
                rdy1  = !entries_q[i].is_load || (i >= int'(LOAD_READY));
                sel1  = SEL_W'(i + 1);
                data1 = io_stage_data[i*XLEN +: XLEN];
            end
            if (entries_q[i].valid && (entries_q[i].rd == io_rs2_addr) &&
                (io_rs2_addr != 5'd0)) begin
                hit2  = 1'b1;
                rdy2  = !entries_q[i].is_load || (i >= int'(LOAD_READY));
                sel2  = SEL_W'(i + 1);
                data2 = io_stage_data[i*XLEN +: XLEN];
            end
        end
    end

    // Operand mux and hazard; an unready winner falls back to the register
    // file value but holds the issuing instruction.
    always_comb begin
        io_rs1_out = io_rs1;
        io_rs1_sel = '0;
        io_rs2_out = io_rs2;
        io_rs2_sel = '0;
        if (hit1 && rdy1) begin
            io_rs1_out = data1;
            io_rs1_sel = sel1;
        end
        if (hit2 && rdy2) begin
            io_rs2_out = data2;
            io_rs2_sel = sel2;
        end
        stall_c   = io_issue_valid && ((hit1 && !rdy1) || (hit2 && !rdy2));
        capture_c = io_issue_valid && io_issue_wen && (io_issue_rd != 5'd0) && !stall_c;
    end

    assign io_stall       = stall_c;
    assign io_stall_count = stall_count_q;

    // Tag pipeline: shift on advance, squash on flush, hold when frozen.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_q[i] <= '0;
            end
        end else if (io_flush) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_q[i].valid <= 1'b0;
            end
        end else if (io_advance) begin
            for (int i = int'(DEPTH) - 1; i >= 1; i--) begin
                entries_q[i] <= entries_q[i-1];
            end
            if (capture_c) begin
                entries_q[0] <= '{valid: 1'b1, rd: io_issue_rd, is_load: io_issue_is_load};
            end else begin
                entries_q[0] <= '0;
            end
        end
    end

    // Saturating count of stalled cycles that would otherwise have advanced.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count_q <= '0;
        end else if (stall_c && io_advance && (stall_count_q != '1)) begin
            stall_count_q <= stall_count_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rs_bypass_unit.sv
// Directed bench for rs_bypass_unit (XLEN=32, DEPTH=3, LOAD_READY=1).
module tb_rs_bypass_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned NVEC  = 23;

    logic                  clock;
    logic                  reset;
    logic                  io_issue_valid;
    logic [4:0]            io_issue_rd;
    logic                  io_issue_wen;
    logic                  io_issue_is_load;
    logic                  io_advance;
    logic                  io_flush;
    logic [4:0]            io_rs1_addr;
    logic [4:0]            io_rs2_addr;
    logic [XLEN-1:0]       io_rs1;
    logic [XLEN-1:0]       io_rs2;
    logic [DEPTH*XLEN-1:0] io_stage_data;
    logic [XLEN-1:0]       io_rs1_out;
    logic [XLEN-1:0]       io_rs2_out;
    logic [2:0]            io_rs1_sel;
    logic [2:0]            io_rs2_sel;
    logic                  io_stall;
    logic [31:0]           io_stall_count;

    rs_bypass_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .LOAD_READY(1)) dut (
        .clock            (clock),
        .reset            (reset),
        .io_issue_valid   (io_issue_valid),
        .io_issue_rd      (io_issue_rd),
        .io_issue_wen     (io_issue_wen),
        .io_issue_is_load (io_issue_is_load),
        .io_advance       (io_advance),
        .io_flush         (io_flush),
        .io_rs1_addr      (io_rs1_addr),
        .io_rs2_addr      (io_rs2_addr),
        .io_rs1           (io_rs1),
        .io_rs2           (io_rs2),
        .io_stage_data    (io_stage_data),
        .io_rs1_out       (io_rs1_out),
        .io_rs2_out       (io_rs2_out),
        .io_rs1_sel       (io_rs1_sel),
        .io_rs2_sel       (io_rs2_sel),
        .io_stall         (io_stall),
        .io_stall_count   (io_stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [31:0] RF1 = 32'h1111_1111;
    localparam logic [31:0] RF2 = 32'h2222_2222;
    localparam logic [31:0] SD0 = 32'h0000_1234;
    localparam logic [31:0] SD1 = 32'h0000_BBBB;
    localparam logic [31:0] SD2 = 32'h0000_CCCC;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [4:0]  rd;
        logic        wen;
        logic        ld;
        logic        adv;
        logic        fl;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [2:0]  e1;
        logic [2:0]  e2;
        logic        est;
        logic [31:0] ecnt;
    } vec_t;

    vec_t vecs [NVEC];
    int   checks;
    int   errors;

    function automatic vec_t mk(input logic rst, input logic iv, input logic [4:0] rd,
                                input logic wen, input logic ld, input logic adv,
                                input logic fl, input logic [4:0] a1, input logic [4:0] a2,
                                input logic [2:0] e1, input logic [2:0] e2,
                                input logic est, input logic [31:0] ecnt);
        vec_t v;
        v.rst = rst; v.iv = iv; v.rd = rd; v.wen = wen; v.ld = ld;
        v.adv = adv; v.fl = fl; v.a1 = a1; v.a2 = a2;
        v.e1 = e1; v.e2 = e2; v.est = est; v.ecnt = ecnt;
        return v;
    endfunction

    // Expected forwarded value from the expected source code.
    function automatic logic [31:0] exp_data(input logic [2:0] sel, input logic [31:0] rf);
        case (sel)
            3'd1:    return SD0;
            3'd2:    return SD1;
            3'd3:    return SD2;
            default: return rf;
        endcase
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic iv, input logic [4:0] rd,
                        input logic wen, input logic ld, input logic adv, input logic fl,
                        input logic [4:0] a1, input logic [4:0] a2);
        @(negedge clock);
        reset = rst; io_issue_valid = iv; io_issue_rd = rd; io_issue_wen = wen;
        io_issue_is_load = ld; io_advance = adv; io_flush = fl;
        io_rs1_addr = a1; io_rs2_addr = a2;
    endtask

    task automatic chk_all(input string tag, input int idx, input logic [2:0] e1,
                           input logic [2:0] e2, input logic est, input logic [31:0] ecnt);
        chk({tag, "_rs1_sel"}, idx, 32'(io_rs1_sel), 32'(e1));
        chk({tag, "_rs1_out"}, idx, io_rs1_out, exp_data(e1, RF1));
        chk({tag, "_rs2_sel"}, idx, 32'(io_rs2_sel), 32'(e2));
        chk({tag, "_rs2_out"}, idx, io_rs2_out, exp_data(e2, RF2));
        chk({tag, "_stall"}, idx, 32'(io_stall), 32'(est));
        chk({tag, "_count"}, idx, io_stall_count, ecnt);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        //            rst iv rd    wen ld adv fl a1 a2  e1 e2 st cnt
        vecs[0]  = mk(1, 1, 5'd5,  1, 0, 1, 0, 5, 0,  0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 5'd5,  1, 0, 1, 0, 0, 0,  0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 5'd0,  0, 0, 1, 0, 5, 5,  1, 1, 0, 0);
        vecs[3]  = mk(0, 1, 5'd7,  1, 0, 1, 0, 5, 7,  2, 0, 0, 0);
        vecs[4]  = mk(0, 1, 5'd7,  1, 0, 1, 0, 5, 7,  3, 1, 0, 0);
        vecs[5]  = mk(0, 0, 5'd0,  0, 0, 1, 0, 7, 7,  1, 1, 0, 0);
        vecs[6]  = mk(0, 1, 5'd3,  1, 1, 1, 0, 7, 0,  2, 0, 0, 0);
        vecs[7]  = mk(0, 1, 5'd10, 1, 0, 1, 0, 3, 7,  0, 3, 1, 0);
        vecs[8]  = mk(0, 1, 5'd10, 1, 0, 1, 0, 3, 3,  2, 2, 0, 1);
        vecs[9]  = mk(0, 1, 5'd0,  1, 0, 1, 0, 0, 3,  0, 3, 0, 1);
        vecs[10] = mk(0, 1, 5'd9,  1, 0, 1, 0, 10, 0, 2, 0, 0, 1);
        vecs[11] = mk(0, 1, 5'd11, 1, 0, 1, 1, 9, 10, 1, 3, 0, 1);
        vecs[12] = mk(0, 0, 5'd0,  0, 0, 1, 0, 9, 11, 0, 0, 0, 1);
        vecs[13] = mk(0, 1, 5'd4,  1, 1, 1, 0, 0, 0,  0, 0, 0, 1);
        vecs[14] = mk(0, 1, 5'd12, 1, 0, 0, 0, 4, 0,  0, 0, 1, 1);
        vecs[15] = mk(0, 0, 5'd0,  0, 0, 0, 0, 4, 4,  0, 0, 0, 1);
        vecs[16] = mk(0, 1, 5'd13, 1, 0, 0, 0, 4, 0,  0, 0, 1, 1);
        vecs[17] = mk(0, 0, 5'd0,  0, 0, 0, 0, 4, 4,  0, 0, 0, 1);
        vecs[18] = mk(0, 1, 5'd14, 1, 0, 1, 0, 4, 0,  0, 0, 1, 1);
        vecs[19] = mk(0, 0, 5'd0,  0, 0, 1, 0, 4, 4,  2, 2, 0, 2);
        vecs[20] = mk(0, 1, 5'd15, 1, 0, 1, 0, 4, 0,  3, 0, 0, 2);
        vecs[21] = mk(1, 1, 5'd16, 1, 0, 0, 1, 15, 15, 1, 1, 0, 2);
        vecs[22] = mk(0, 1, 5'd0,  1, 0, 1, 0, 15, 4, 0, 0, 0, 0);

        io_rs1 = RF1;
        io_rs2 = RF2;
        io_stage_data = {SD2, SD1, SD0};
        reset = 1'b1; io_issue_valid = 1'b0; io_issue_rd = '0; io_issue_wen = 1'b0;
        io_issue_is_load = 1'b0; io_advance = 1'b0; io_flush = 1'b0;
        io_rs1_addr = '0; io_rs2_addr = '0;
        repeat (2) @(posedge clock);

        // Table: drive at negedge, check combinational outputs, edge applies.
        for (int v = 0; v < int'(NVEC); v++) begin
            step(vecs[v].rst, vecs[v].iv, vecs[v].rd, vecs[v].wen, vecs[v].ld,
                 vecs[v].adv, vecs[v].fl, vecs[v].a1, vecs[v].a2);
            #1;
            chk_all("vec", v, vecs[v].e1, vecs[v].e2, vecs[v].est, vecs[v].ecnt);
        end

        // Saturation: preload counter near the top, then three stalled advances.
        step(0, 1, 5'd8, 1, 1, 1, 0, 0, 0);
        #1;
        chk_all("sat_ld0", 0, 0, 0, 0, 0);
        @(negedge clock);
        force dut.stall_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_count_q;
        io_issue_valid = 1'b1; io_issue_rd = 5'd1; io_issue_wen = 1'b1;
        io_issue_is_load = 1'b0; io_advance = 1'b1; io_flush = 1'b0;
        io_rs1_addr = 5'd8; io_rs2_addr = 5'd0;
        #1;
        chk_all("sat_st1", 1, 0, 0, 1, 32'hFFFF_FFFE);
        step(0, 1, 5'd8, 1, 1, 1, 0, 0, 8);
        #1;
        chk_all("sat_ld1", 2, 0, 2, 0, 32'hFFFF_FFFF);
        step(0, 1, 5'd1, 1, 0, 1, 0, 8, 0);
        #1;
        chk_all("sat_st2", 3, 0, 0, 1, 32'hFFFF_FFFF);
        step(0, 1, 5'd8, 1, 1, 1, 0, 0, 0);
        #1;
        chk_all("sat_ld2", 4, 0, 0, 0, 32'hFFFF_FFFF);
        step(0, 1, 5'd1, 1, 0, 1, 0, 8, 0);
        #1;
        chk_all("sat_st3", 5, 0, 0, 1, 32'hFFFF_FFFF);
        step(0, 0, 5'd0, 0, 0, 1, 0, 8, 8);
        #1;
        chk_all("sat_end", 6, 2, 2, 0, 32'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
